palette_fade_ctrl: RTL

- Owns the 16-entry x 12-bit sprite colour palette used by the VGA pixel path and sequences frame-synchronous fade-out/fade-in of the whole palette (game-over, level transitions).
- Sits between the sprite ROM index output and the VGA colour mux; provides a registered per-pixel colour lookup, a global brightness level and a host palette write port.
- Index 0 is the chroma-key (transparent) entry and is never scaled.

---
 rtl/palette_pkg.sv | 22 ++
 rtl/palette_scale.sv | 18 +
 rtl/palette_fade_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/palette_pkg.sv
// Shared types and constants for the sprite palette / fade controller.
package palette_pkg;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  typedef enum logic [1:0] {STEADY, FADE_OUT, FADE_IN} fade_state_t;

  localparam int         NUM_CH  = 3;
  localparam logic [3:0] LVL_MAX = 4'hF;
  localparam logic [3:0] LVL_MIN = 4'h0;

  // Entry 0 is the chroma key and is never scaled.
  localparam rgb12_t DEFAULT_PALETTE [16] = '{
    12'hE00, 12'h000, 12'hBA7, 12'h041, 12'h420, 12'h052, 12'h021, 12'h950,
    12'h243, 12'h640, 12'h010, 12'h372, 12'h011, 12'h210, 12'h222, 12'h142
  };

endpackage

// File: rtl/palette_scale.sv
// One colour channel scaled by brightness: (c * (lvl+1)) >> 4.
module palette_scale (
  input  logic [3:0] chan,
  input  logic [3:0] lvl,
  output logic [3:0] scaled
);

  logic [7:0] prod;
  logic [7:0] lvl_p1;

  // 15*16 = 240 fits in 8 bits, so no overflow guard is needed.
  always_comb begin
    lvl_p1 = {4'd0, lvl} + 8'd1;
    prod   = {4'd0, chan} * lvl_p1;
    scaled = prod[7:4];
  end

endmodule

// File: rtl/palette_fade_ctrl.sv
// Sprite palette owner with frame-synchronous global fade.
// Optional macro PALETTE_FADE_WRITE_EN: makes the palette a writable
// register array; without it the palette is the constant default and
// the wr_* port is ignored.
module palette_fade_ctrl
  import palette_pkg::*;
#(
  parameter int STEP_FRAMES = 4,
  parameter int INIT_LEVEL  = 15
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        vsync_pulse,
  input  logic        fade_out_req,
  input  logic        fade_in_req,
  input  logic [3:0]  pix_index,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic        transparent,
  output logic [3:0]  level,
  output logic        busy,
  output logic        done,
  input  logic        wr_en,
  input  logic [3:0]  wr_addr,
  input  logic [11:0] wr_data
);

  localparam logic [7:0] CNT_LAST = 8'(STEP_FRAMES - 1);
  localparam logic [3:0] LVL_INIT = 4'(INIT_LEVEL);

  fade_state_t state, state_n;
  logic [7:0]  cnt, cnt_n;
  logic [3:0]  level_n;
  logic        done_n;

  rgb12_t                      src;
  logic [NUM_CH-1:0][3:0]      ch_in;
  logic [NUM_CH-1:0][3:0]      ch_sc;

`ifdef PALETTE_FADE_WRITE_EN
  rgb12_t pal [16];

  // Palette storage: reset reloads defaults, writes land at the edge so a
  // same-cycle lookup still sees the old entry.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) pal <= DEFAULT_PALETTE;
    else if (wr_en) pal[wr_addr] <= rgb12_t'(wr_data);
  end

  assign src = pal[pix_index];
`else
  logic unused_wr;
  assign unused_wr = ^{wr_en, wr_addr, wr_data};
  assign src       = DEFAULT_PALETTE[pix_index];
`endif

  // Three channel lanes share one brightness level.
  assign ch_in = {src.r, src.g, src.b};

  palette_scale u_scale [NUM_CH-1:0] (
    .chan   (ch_in),
    .lvl    (level),
    .scaled (ch_sc)
  );

  // Registered lookup; the chroma key bypasses scaling.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      {red, green, blue} <= '0;
      transparent        <= 1'b0;
    end else begin
      transparent        <= (pix_index == 4'd0);
      {red, green, blue} <= (pix_index == 4'd0) ? src : ch_sc;
    end
  end

  // Fade state, level, frame counter and done pulse registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= STEADY;
      level <= LVL_INIT;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      level <= level_n;
      cnt   <= cnt_n;
      done  <= done_n;
    end
  end

  // Next-state: requests take priority over a coincident vsync step;
  // fade_out wins when both requests arrive together.
  always_comb begin
    state_n = state;
    level_n = level;
    cnt_n   = cnt;
    done_n  = 1'b0;
    case (state)
      STEADY: begin
        if (fade_out_req) begin
          if (level != LVL_MIN) begin state_n = FADE_OUT; cnt_n = '0; end
          else done_n = 1'b1;
        end else if (fade_in_req) begin
          if (level != LVL_MAX) begin state_n = FADE_IN; cnt_n = '0; end
          else done_n = 1'b1;
        end
      end
      FADE_OUT: begin
        if (fade_in_req && !fade_out_req) begin
          // Reversal while still at the new target simply finishes.
          if (level == LVL_MAX) begin state_n = STEADY; done_n = 1'b1; end
          else begin state_n = FADE_IN; cnt_n = '0; end
        end else if (vsync_pulse) begin
          if (cnt == CNT_LAST) begin
            cnt_n   = '0;
            level_n = level - 4'd1;
            if (level == 4'd1) begin state_n = STEADY; done_n = 1'b1; end
          end else cnt_n = cnt + 8'd1;
        end
      end
      FADE_IN: begin
        if (fade_out_req) begin
          if (level == LVL_MIN) begin state_n = STEADY; done_n = 1'b1; end
          else begin state_n = FADE_OUT; cnt_n = '0; end
        end else if (vsync_pulse) begin
          if (cnt == CNT_LAST) begin
            cnt_n   = '0;
            level_n = level + 4'd1;
            if (level == 4'd14) begin state_n = STEADY; done_n = 1'b1; end
          end else cnt_n = cnt + 8'd1;
        end
      end
      default: state_n = STEADY;
    endcase
  end

  // Moore outputs.
  always_comb begin
    busy = (state != STEADY);
  end

endmodule
